// File: rtl/jk_input_conditioner.sv
// Conditions raw asynchronous J/K requests for the master-slave JK flip-flop:
// synchronise, reject short pulses, and provide clean levels, rise strobes and a settled flag.
module jk_input_conditioner #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic j_raw,
   input  logic k_raw,
   output logic j,
   output logic k,
   output logic j_rise,
   output logic k_rise,
   output logic settled
);

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

   // Channel index 0 is J, index 1 is K; the two channels never interact.
   logic [1:0]                  raw;
   logic [1:0]                  smp;
   logic [1:0][SYNC_STAGES-1:0] sync_q;
   logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;
   logic [1:0]                  filt_q, filt_d;
   logic [1:0]                  rise_q, rise_d;

   assign raw = {k_raw, j_raw};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         cnt_q  <= '0;
         filt_q <= '0;
         rise_q <= '0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            sync_q[c][0] <= raw[c];
            for (int i = 1; i < SYNC_STAGES; i++) begin
               sync_q[c][i] <= sync_q[c][i-1];
            end
         end
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
         rise_q <= rise_d;
      end
   end

   always_comb begin
      smp    = '0;
      cnt_d  = cnt_q;
      filt_d = filt_q;
      rise_d = '0;
      for (int c = 0; c < 2; c++) begin
         smp[c] = sync_q[c][SYNC_STAGES-1];
         // Any return of smp to the accepted level restarts the count, so bounces never add up.
         if (smp[c] == filt_q[c]) begin
            cnt_d[c] = '0;
         end else if (cnt_q[c] == CntLast) begin
            filt_d[c] = smp[c];
            cnt_d[c]  = '0;
            rise_d[c] = smp[c];
         end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
         end
      end
   end

   assign j       = filt_q[0];
   assign k       = filt_q[1];
   assign j_rise  = rise_q[0];
   assign k_rise  = rise_q[1];
   assign settled = (smp == filt_q);

endmodule

// File: tb/tb_jk_input_conditioner.sv
// Directed bench for jk_input_conditioner: per-edge stimulus strings with hand-computed
// expected levels, strobes and settled flag.
module tb_jk_input_conditioner;

   logic clk;
   logic reset;
   logic j_raw;
   logic k_raw;
   logic j;
   logic k;
   logic j_rise;
   logic k_rise;
   logic settled;

   int n_vec;
   int n_err;

   jk_input_conditioner #(
      .SYNC_STAGES   (2),
      .STABLE_CYCLES (4),
      .CNT_W         (3)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .j_raw   (j_raw),
      .k_raw   (k_raw),
      .j       (j),
      .k       (k),
      .j_rise  (j_rise),
      .k_rise  (k_rise),
      .settled (settled)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   // Move to 2 ns before the next rising edge.
   task automatic align();
      @(posedge clk);
      #8;
   endtask

   // One character per edge, left to right. Raw inputs are applied 2 ns before each edge;
   // outputs are sampled 1 ns after it. '-' in an expectation string means don't care.
   // Entered and left 2 ns before an edge so calls chain back to back.
   task automatic run_vec(input string name, input string jp, input string kp,
                          input string je, input string ke, input string jre,
                          input string kre, input string se);
      byte c;
      for (int e = 0; e < jp.len(); e++) begin
         j_raw = (jp[e] == "1");
         k_raw = (kp[e] == "1");
         @(posedge clk);
         #1;
         check($sformatf("%s e%0d no_x", name, e + 1),
               $isunknown({j, k, j_rise, k_rise, settled}), 1'b0);
         c = je[e];
         if (c != "-") check($sformatf("%s e%0d j", name, e + 1), j, c == "1");
         c = ke[e];
         if (c != "-") check($sformatf("%s e%0d k", name, e + 1), k, c == "1");
         c = jre[e];
         if (c != "-") check($sformatf("%s e%0d j_rise", name, e + 1), j_rise, c == "1");
         c = kre[e];
         if (c != "-") check($sformatf("%s e%0d k_rise", name, e + 1), k_rise, c == "1");
         c = se[e];
         if (c != "-") check($sformatf("%s e%0d settled", name, e + 1), settled, c == "1");
         #7;
      end
   endtask

   task automatic check_reset_state(input string name);
      check({name, " j"}, j, 1'b0);
      check({name, " k"}, k, 1'b0);
      check({name, " j_rise"}, j_rise, 1'b0);
      check({name, " k_rise"}, k_rise, 1'b0);
      check({name, " settled"}, settled, 1'b1);
      check({name, " no_x"}, $isunknown({j, k, j_rise, k_rise, settled}), 1'b0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      j_raw = 1'b1;
      k_raw = 1'b1;

      // Reset held across a clock edge with both raw inputs high.
      #3;
      check_reset_state("rst_t3");
      #3;
      check_reset_state("rst_t6");
      #4;
      reset = 1'b0;
      j_raw = 1'b0;
      k_raw = 1'b0;
      align();
      run_vec("idle0", "00000000", "00000000", "00000000", "00000000",
              "00000000", "00000000", "11111111");

      // Latency: J rises on the 6th edge, strobes once, settled low on edges 2-5.
      run_vec("lat_rise", "111111111111", "000000000000", "000001111111", "000000000000",
              "000001000000", "000000000000", "100001111111");
      run_vec("lat_fall", "000000000000", "000000000000", "111110000000", "000000000000",
              "000000000000", "000000000000", "100001111111");

      // 1 ns K pulse during clk high, never sampled.
      #3;
      k_raw = 1'b1;
      #1;
      k_raw = 1'b0;
      #6;
      run_vec("glitch1ns", "0000000000", "0000000000", "0000000000", "0000000000",
              "0000000000", "0000000000", "1111111111");

      // 3-period K pulse is rejected.
      run_vec("pulse3", "0000000000000", "1110000000000", "0000000000000", "0000000000000",
              "0000000000000", "0000000000000", "-------------");

      // 4-period K pulse passes, 4 periods wide, 6 edges late.
      run_vec("pulse4", "00000000000000000", "11110000000000000", "00000000000000000",
              "00000111100000000", "00000000000000000", "00000100000000000",
              "-----------------");

      // Bounce: 2 high, 1 low, 4 high; J rises only after the final run, one strobe.
      run_vec("bounce", "1101111000000000000", "0000000000000000000",
              "0000000011110000000", "0000000000000000000",
              "0000000010000000000", "0000000000000000000", "-------------------");

      // Simultaneous rise then simultaneous fall.
      run_vec("both_rise", "1111111111", "1111111111", "0000011111", "0000011111",
              "0000010000", "0000010000", "1000011111");
      run_vec("both_fall", "0000000000", "0000000000", "1111100000", "1111100000",
              "0000000000", "0000000000", "1000011111");

      // Reset three edges into a J change; the pending change is discarded.
      j_raw = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk);
         #1;
         check($sformatf("pre_rst e%0d j", e), j, 1'b0);
      end
      reset = 1'b1;
      #1;
      check_reset_state("mid_rst");
      @(posedge clk);
      #1;
      check_reset_state("mid_rst_edge");
      #2;
      reset = 1'b0;
      #5;
      run_vec("post_rst", "11111111", "00000000", "00000111", "00000000",
              "00000100", "00000000", "-0000111");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/jk_input_conditioner.md
Name: jk_input_conditioner

Overview:
- Upstream conditioning stage for the master-slave JK flip-flop.
- Takes raw, asynchronous j/k requests and synchronises each one into the clk domain.
- Rejects any level change shorter than STABLE_CYCLES sampled cycles, so the flip-flop never sees a glitch during clk high.
- Drives clean j/k levels plus single-cycle rise strobes and a settled flag to the flip-flop and to downstream counters.

Parameters:
- SYNC_STAGES, 2: depth of the per-input synchroniser chain; must be >= 1.
- STABLE_CYCLES, 4: consecutive cycles a synchronised level must hold before it is accepted; must be >= 1.
- CNT_W, 3: stability counter width; must satisfy 2^CNT_W >= STABLE_CYCLES.

Ports:
- clk, input, 1: single system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high; clears all state immediately, independent of clk.
- j_raw, input, 1: unsynchronised J request; may change at any time.
- k_raw, input, 1: unsynchronised K request; may change at any time.
- j, output, 1: filtered, synchronised J level to the flip-flop.
- k, output, 1: filtered, synchronised K level to the flip-flop.
- j_rise, output, 1: one-cycle strobe when j goes 0->1.
- k_rise, output, 1: one-cycle strobe when k goes 0->1.
- settled, output, 1: high when neither channel has a pending change.

Behaviour:
- **Reset:** while reset is high, every synchroniser flop, counter, j, k, j_rise and k_rise is 0, and settled is 1. On release, the first rising edge operates normally.
- **Reset mid-count:** asserting reset mid-count discards the pending change with no partial update.
- **Channels:** each channel (J, K) is identical and fully independent; there is no cross-coupling.
- **Synchroniser:** s[0] <= raw; s[i] <= s[i-1]. The sampled value is smp = s[SYNC_STAGES-1].
- **Stability counter** (per channel, cnt, CNT_W bits), evaluated each edge:
  - If smp == filt: cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1: filt <= smp, cnt <= 0.
  - Else: cnt <= cnt+1.
- **Filter rules:**
  - Any return of smp to filt before acceptance restarts the count from 0; bounces never accumulate.
  - STABLE_CYCLES = 1 degenerates to filt following smp with one edge of delay.
- **Latency:** a raw change set up before edge N and held appears on j/k at edge N+SYNC_STAGES+STABLE_CYCLES-1, i.e. the 6th edge for the defaults.
- **Rejection:** a raw pulse seen on smp for fewer than STABLE_CYCLES consecutive cycles produces no output change.
- **Rise strobes:**
  - j_rise is registered and asserted on the same edge filt goes 0->1; it is high for exactly one cycle.
  - j_rise is never asserted for a 1->0 change. k_rise behaves the same way.
- **Settled flag:** settled = (smp_j == j) && (smp_k == k), combinational from registered state.
- **Simultaneous changes:** if both inputs change together and hold, j and k update on the same edge and both strobes fire together. This delivers a clean J=K=1 (toggle) request.
- **Outputs:** j and k are driven only from flops, so they are glitch-free across the whole clk period.
- **Counter wrap:** cnt never exceeds STABLE_CYCLES-1, so it cannot wrap.

Test Plan:
- **Reset:** reset=1 for 10 ns with j_raw=k_raw=1, then release. Required: j=k=0, strobes 0 and settled=1 during reset, and no X at any time.
- **Latency:** with a 10 ns clk, raise j_raw 2 ns before an edge and hold it. Required: j=1 and j_rise=1 on the 6th edge; j_rise=0 on the next edge; settled=0 from edge 2 through 5, and 1 again after edge 6.
- **Glitch rejection:**
  - A 1 ns k_raw pulse during clk high: k stays 0, no k_rise.
  - A k_raw pulse of 3 clock periods: k stays 0.
  - A k_raw pulse of 4 periods: k=1 for exactly 4 periods, delayed by 6 edges.
- **Bounce:** j_raw high 2 cycles, low 1 cycle, then high 4 cycles. Required: j rises only after the final 4-cycle run, and exactly one j_rise is produced.
- **Simultaneous change:** raise j_raw and k_raw on the same edge. Required: j and k go 1 on the same edge and j_rise and k_rise coincide. Dropping both together clears j and k together with no strobes.
- **Reset mid-count:** assert reset 3 edges after a j_raw rise, then release with j_raw still 1. Required: j=0 during reset; after release j rises 6 edges later, with no earlier change.
